fluid_pipe_elastic: RTL

//  Parametrised elastic (fluid) successor to the four-register fluid datapath test block.

---
 rtl/fluid_pipe_elastic.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/fluid_pipe_elastic.sv
// fluid_pipe_elastic
// Four-stage elastic datapath computing c=a&b, d=a|b, e=(b^d)^i3, f=(i3&e)^e.
// Each stage is an elastic buffer joined to its neighbours by valid/stop handshakes.
// Every token carries its own operands, so the outputs always belong to one input token.

// One elastic stage. DEPTH==1 is a pipeline register with a combinational stop.
// DEPTH>=2 is a circular FIFO whose upstream stop is a register.
module fluid_pipe_elastic_stage #(
   parameter int DW    = 8,
   parameter int DEPTH = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_valid,
   output logic          o_stop,
   input  logic [DW-1:0] i_data,
   output logic          o_valid,
   input  logic          i_stop,
   output logic [DW-1:0] o_data
);

   generate
      if (DEPTH == 1) begin : g_reg
         logic          r_full;
         logic [DW-1:0] r_data;
         logic          w_push;
         logic          w_pop;

         assign o_stop  = r_full && i_stop;
         assign w_push  = i_valid && !o_stop;
         assign w_pop   = r_full && !i_stop;
         assign o_valid = r_full;
         assign o_data  = r_data;

         // Single entry: a push may overlap a pop, so the stage streams at full rate
         always_ff @(posedge clk) begin
            if (reset) begin
               r_full <= 1'b0;
               r_data <= '0;
            end else begin
               if (w_push) begin
                  r_data <= i_data;
               end
               if (w_push) begin
                  r_full <= 1'b1;
               end else if (w_pop) begin
                  r_full <= 1'b0;
               end
            end
         end
      end else begin : g_fifo
         localparam int PW = $clog2(DEPTH);
         localparam int CW = $clog2(DEPTH + 1);

         logic [DW-1:0] r_mem [DEPTH];
         logic [PW-1:0] r_rd;
         logic [PW-1:0] r_wr;
         logic [CW-1:0] r_cnt;
         logic          r_stop;
         logic          w_push;
         logic          w_pop;
         logic [CW-1:0] w_cntNext;

         assign o_stop  = r_stop;
         assign w_push  = i_valid && !r_stop;
         assign w_pop   = (r_cnt != '0) && !i_stop;
         assign o_valid = (r_cnt != '0);
         assign o_data  = r_mem[r_rd];

         // Next fill level; a push and a pop together leave it unchanged
         always_comb begin
            w_cntNext = r_cnt;
            if (w_push && !w_pop) begin
               w_cntNext = r_cnt + CW'(1);
            end else if (!w_push && w_pop) begin
               w_cntNext = r_cnt - CW'(1);
            end
         end

         // Circular storage; stop is registered so a full FIFO refuses a push even while popping
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < DEPTH; i++) begin
                  r_mem[i] <= '0;
               end
               r_rd   <= '0;
               r_wr   <= '0;
               r_cnt  <= '0;
               r_stop <= 1'b0;
            end else begin
               if (w_push) begin
                  r_mem[r_wr] <= i_data;
                  if (r_wr == PW'(DEPTH - 1)) begin
                     r_wr <= '0;
                  end else begin
                     r_wr <= r_wr + PW'(1);
                  end
               end
               if (w_pop) begin
                  if (r_rd == PW'(DEPTH - 1)) begin
                     r_rd <= '0;
                  end else begin
                     r_rd <= r_rd + PW'(1);
                  end
               end
               r_cnt  <= w_cntNext;
               r_stop <= (w_cntNext == CW'(DEPTH));
            end
         end
      end
   endgenerate

endmodule

// Top level: four stages chained with the bitwise datapath between them
module fluid_pipe_elastic #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1,
   parameter int CNTW  = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   output logic                           in_stop,
   input  logic [WIDTH-1:0]               in1,
   input  logic [WIDTH-1:0]               in2,
   input  logic [WIDTH-1:0]               in3,
   output logic                           out_valid,
   input  logic                           out_stop,
   output logic [WIDTH-1:0]               out_c,
   output logic [WIDTH-1:0]               out_d,
   output logic [WIDTH-1:0]               out_f,
   output logic [$clog2(4*DEPTH+1)-1:0]   occupancy,
   output logic [CNTW-1:0]                done_cnt
);

   localparam int W  = WIDTH;
   localparam int OW = $clog2(4 * DEPTH + 1);

   logic [3*W-1:0] w_s1In, w_s1Out;
   logic [4*W-1:0] w_s2In, w_s2Out;
   logic [4*W-1:0] w_s3In, w_s3Out;
   logic [3*W-1:0] w_s4In, w_s4Out;
   logic           w_v1, w_v2, w_v3;
   logic           w_stop12, w_stop23, w_stop34;

   logic [W-1:0]   w_a1, w_b1, w_i1;
   logic [W-1:0]   w_c2, w_d2, w_b2, w_i2;
   logic [W-1:0]   w_c3, w_d3, w_e3, w_i3;

   logic [OW-1:0]   r_occ;
   logic [CNTW-1:0] r_done;
   logic            w_inXfer;
   logic            w_outXfer;

   assign w_s1In = {in1, in2, in3};
   assign {w_a1, w_b1, w_i1} = w_s1Out;
   assign w_s2In = {w_a1 & w_b1, w_a1 | w_b1, w_b1, w_i1};
   assign {w_c2, w_d2, w_b2, w_i2} = w_s2Out;
   assign w_s3In = {w_c2, w_d2, (w_b2 ^ w_d2) ^ w_i2, w_i2};
   assign {w_c3, w_d3, w_e3, w_i3} = w_s3Out;
   assign w_s4In = {w_c3, w_d3, (w_i3 & w_e3) ^ w_e3};
   assign {out_c, out_d, out_f} = w_s4Out;

   fluid_pipe_elastic_stage #(.DW(3*W), .DEPTH(DEPTH)) u_s1 (
      .clk(clk), .reset(reset),
      .i_valid(in_valid), .o_stop(in_stop), .i_data(w_s1In),
      .o_valid(w_v1), .i_stop(w_stop12), .o_data(w_s1Out)
   );

   fluid_pipe_elastic_stage #(.DW(4*W), .DEPTH(DEPTH)) u_s2 (
      .clk(clk), .reset(reset),
      .i_valid(w_v1), .o_stop(w_stop12), .i_data(w_s2In),
      .o_valid(w_v2), .i_stop(w_stop23), .o_data(w_s2Out)
   );

   fluid_pipe_elastic_stage #(.DW(4*W), .DEPTH(DEPTH)) u_s3 (
      .clk(clk), .reset(reset),
      .i_valid(w_v2), .o_stop(w_stop23), .i_data(w_s3In),
      .o_valid(w_v3), .i_stop(w_stop34), .o_data(w_s3Out)
   );

   fluid_pipe_elastic_stage #(.DW(3*W), .DEPTH(DEPTH)) u_s4 (
      .clk(clk), .reset(reset),
      .i_valid(w_v3), .o_stop(w_stop34), .i_data(w_s4In),
      .o_valid(out_valid), .i_stop(out_stop), .o_data(w_s4Out)
   );

   assign w_inXfer  = in_valid && !in_stop;
   assign w_outXfer = out_valid && !out_stop;
   assign occupancy = r_occ;
   assign done_cnt  = r_done;

   // Token bookkeeping: occupancy tracks entries held, done counts deliveries and wraps freely
   always_ff @(posedge clk) begin
      if (reset) begin
         r_occ  <= '0;
         r_done <= '0;
      end else begin
         if (w_inXfer && !w_outXfer) begin
            r_occ <= r_occ + OW'(1);
         end else if (!w_inXfer && w_outXfer) begin
            r_occ <= r_occ - OW'(1);
         end
         if (w_outXfer) begin
            r_done <= r_done + CNTW'(1);
         end
      end
   end

endmodule
